// File: rtl/puc_cpu_gen2.sv
// puc_cpu_gen2: single-cycle PUC processor core with a register file,
// a return stack, an instruction-valid stall handshake and a fault/halt state.
// Optional feature macro: PUC_STACK_GUARD_EN. When it is defined, stack
// overflow or underflow sets a sticky fault and halts the core. When it is
// undefined, the stack pointer wraps and the core never halts.
module puc_cpu_gen2 #(
  parameter int REGISTER_WIDTH    = 8,
  parameter int PC_WIDTH          = 8,
  parameter int NUM_REGS          = 8,
  parameter int STACK_DEPTH       = 16,
  parameter int INSTRUCTION_WIDTH = 32
) (
  input  logic                           clock,
  input  logic                           isReset,
  input  logic [INSTRUCTION_WIDTH-1:0]   instruction,
  input  logic                           instrValid,
  input  logic                           switch,
  output logic [PC_WIDTH-1:0]            pc,
  output logic [REGISTER_WIDTH-1:0]      register1Value,
  output logic [$clog2(STACK_DEPTH):0]   stackOffset,
  output logic                           fault,
  output logic                           halted
);

  localparam int RIDX = $clog2(NUM_REGS);
  localparam int SW   = $clog2(STACK_DEPTH);

  localparam logic [4:0] OP_LOAD       = 5'd0;
  localparam logic [4:0] OP_ADD        = 5'd2;
  localparam logic [4:0] OP_JUMP       = 5'd3;
  localparam logic [4:0] OP_RESET      = 5'd4;
  localparam logic [4:0] OP_IF0JUMP    = 5'd5;
  localparam logic [4:0] OP_IF1JUMP    = 5'd6;
  localparam logic [4:0] OP_LOADSWITCH = 5'd7;
  localparam logic [4:0] OP_CALL       = 5'd8;
  localparam logic [4:0] OP_EXIT       = 5'd9;
  localparam logic [4:0] OP_INCREMENT  = 5'd11;
  localparam logic [4:0] OP_LSHIFT     = 5'd13;
  localparam logic [4:0] OP_DECREMENT  = 5'd14;
  localparam logic [4:0] OP_RSHIFT     = 5'd15;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [PC_WIDTH-1:0]       PC_ONE     = PC_WIDTH'(1);
  localparam logic [REGISTER_WIDTH-1:0] REG_ONE    = REGISTER_WIDTH'(1);
  localparam logic [SW:0]               OFF_ONE    = (SW+1)'(1);
  localparam logic [SW-1:0]             IDX_ONE    = SW'(1);
  localparam logic [SW:0]               DEPTH_FULL = (SW+1)'(STACK_DEPTH);

  logic [PC_WIDTH-1:0]       r_pc;
  logic [0:0]                r_state;
  logic                      r_fault;
  logic [SW:0]               r_stackOffset;
  logic [REGISTER_WIDTH-1:0] r_regs  [NUM_REGS];
  logic [PC_WIDTH-1:0]       r_stack [STACK_DEPTH];

  logic [4:0]                w_opcode;
  logic [RIDX-1:0]           w_a1Idx;
  logic [RIDX-1:0]           w_a2Idx;
  logic [RIDX-1:0]           w_aOutIdx;
  logic [7:0]                w_value;
  logic [REGISTER_WIDTH-1:0] w_rA;
  logic [REGISTER_WIDTH-1:0] w_rB;
  logic [PC_WIDTH-1:0]       w_target;
  logic [PC_WIDTH-1:0]       w_pcPlusOne;
  logic [SW-1:0]             w_pushIdx;
  logic [SW-1:0]             w_popIdx;
  logic                      w_wrEn;
  logic [REGISTER_WIDTH-1:0] w_wrData;
  logic [PC_WIDTH-1:0]       w_pcNext;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_clear;
  logic                      w_stackErr;
  logic [SW:0]               w_offNext;
  logic                      w_unusedBits;

  assign w_opcode    = instruction[28:24];
  assign w_a1Idx     = instruction[16 +: RIDX];
  assign w_a2Idx     = instruction[8 +: RIDX];
  assign w_aOutIdx   = instruction[0 +: RIDX];
  assign w_value     = instruction[15:8];
  assign w_unusedBits = ^instruction;

  // Register 0 is hard-wired to read as zero regardless of array contents.
  assign w_rA = (w_a1Idx == '0) ? '0 : r_regs[w_a1Idx];
  assign w_rB = (w_a2Idx == '0) ? '0 : r_regs[w_a2Idx];

  assign w_target    = PC_WIDTH'(w_value);
  assign w_pcPlusOne = r_pc + PC_ONE;
  assign w_pushIdx   = r_stackOffset[SW-1:0];
  // Low-bit decrement also yields entry STACK_DEPTH-1 on a wrapped underflow.
  assign w_popIdx    = r_stackOffset[SW-1:0] - IDX_ONE;

  // Decode the current instruction into a register write, next pc and stack action.
  always_comb begin
    w_wrEn     = 1'b0;
    w_wrData   = '0;
    w_pcNext   = w_pcPlusOne;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_clear    = 1'b0;
    w_stackErr = 1'b0;
    case (w_opcode)
      OP_LOAD: begin
        w_wrEn   = 1'b1;
        w_wrData = REGISTER_WIDTH'(w_value);
      end
      OP_ADD: begin
        w_wrEn   = 1'b1;
        w_wrData = w_rA + w_rB;
      end
      OP_INCREMENT: begin
        w_wrEn   = 1'b1;
        w_wrData = w_rA + REG_ONE;
      end
      OP_DECREMENT: begin
        w_wrEn   = 1'b1;
        w_wrData = w_rA - REG_ONE;
      end
      OP_LSHIFT: begin
        w_wrEn   = 1'b1;
        w_wrData = w_rA << 1;
      end
      OP_RSHIFT: begin
        w_wrEn   = 1'b1;
        w_wrData = w_rA >> 1;
      end
      OP_LOADSWITCH: begin
        w_wrEn   = 1'b1;
        w_wrData = REGISTER_WIDTH'(switch);
      end
      OP_JUMP: w_pcNext = w_target;
      OP_IF0JUMP: if (w_rA == '0) w_pcNext = w_target;
      OP_IF1JUMP: if (w_rA != '0) w_pcNext = w_target;
      OP_CALL: begin
        w_push   = 1'b1;
        w_pcNext = w_target;
`ifdef PUC_STACK_GUARD_EN
        if (r_stackOffset == DEPTH_FULL) w_stackErr = 1'b1;
`endif
      end
      OP_EXIT: begin
        w_pop    = 1'b1;
        w_pcNext = r_stack[w_popIdx];
`ifdef PUC_STACK_GUARD_EN
        if (r_stackOffset == '0) w_stackErr = 1'b1;
`endif
      end
      OP_RESET: begin
        w_pcNext = '0;
        w_clear  = 1'b1;
      end
      default: ;
    endcase
  end

  // Next return-stack depth: saturating range with the guard, modulo depth without it.
  always_comb begin
    w_offNext = r_stackOffset;
    if (w_clear) begin
      w_offNext = '0;
    end else if (w_push) begin
`ifdef PUC_STACK_GUARD_EN
      w_offNext = r_stackOffset + OFF_ONE;
`else
      w_offNext = {1'b0, r_stackOffset[SW-1:0] + IDX_ONE};
`endif
    end else if (w_pop) begin
`ifdef PUC_STACK_GUARD_EN
      w_offNext = r_stackOffset - OFF_ONE;
`else
      w_offNext = {1'b0, w_popIdx};
`endif
    end
  end

  // Commit one instruction per valid cycle; a stack error halts without side effects.
  always_ff @(posedge clock) begin
    if (isReset) begin
      r_pc          <= '0;
      r_state       <= ST_RUN;
      r_fault       <= 1'b0;
      r_stackOffset <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
    end else if (r_state == ST_RUN && instrValid) begin
      if (w_stackErr) begin
        r_fault <= 1'b1;
        r_state <= ST_HALT;
      end else begin
        r_pc          <= w_pcNext;
        r_stackOffset <= w_offNext;
        if (w_wrEn && w_aOutIdx != '0) r_regs[w_aOutIdx] <= w_wrData;
        if (w_push) r_stack[w_pushIdx] <= w_pcPlusOne;
      end
    end
  end

  assign pc             = r_pc;
  assign register1Value = r_regs[1];
  assign stackOffset    = r_stackOffset;
  assign fault          = r_fault;
  assign halted         = (r_state == ST_HALT);

endmodule

// File: doc/puc_cpu_gen2.md
# puc_cpu_gen2

Parametrised second-generation PUC processor core. Executes one instruction per clock from an external instruction memory, with a generic register file and a configurable-depth return stack. An instruction-valid handshake allows stalling, and a fault/halt state covers stack misuse. It sits at the top of the design, between the instruction memory and the board I/O (switch input, register 1 output).

## Interface
Parameters:
- REGISTER_WIDTH, 8: data width of every register and of the ALU.
- PC_WIDTH, 8: program counter width; instruction address space is 2^PC_WIDTH.
- NUM_REGS, 8: register count (power of two, 2..256). Register 0 reads as zero.
- STACK_DEPTH, 16: return stack entries (power of two, 2..256).
- INSTRUCTION_WIDTH, 32: instruction word width (fixed at 32).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- isReset  in  1  synchronous, active-high reset.
- instruction  in  32  instruction at address pc; combinational from memory.
- instrValid  in  1  instruction is valid this cycle; low means stall.
- switch  in  1  board switch, read by LOADSWITCH7.
- pc  out  PC_WIDTH  registered program counter.
- register1Value  out  REGISTER_WIDTH  current contents of register 1.
- stackOffset  out  log2(STACK_DEPTH)+1  current return-stack depth.
- fault  out  1  sticky; set on stack overflow or underflow.
- halted  out  1  core is in the HALT state.

## Operation
- Field layout:
  - Opcode: instruction[28:24] (5 bits).
  - a1: [23:16].
  - a2 / value: [15:8].
  - aOut: [7:0].
  - Register indices are the low log2(NUM_REGS) bits of each address field.
- Opcodes and their effects:
  - LOAD0: r[aOut] = value (zero-extended or truncated to REGISTER_WIDTH).
  - ADD2: r[aOut] = r[a1] + r[a2], modulo 2^REGISTER_WIDTH.
  - INCREMENT11 / DECREMENT14: r[aOut] = r[a1] ± 1, wrapping.
  - LSHIFT13 / RSHIFT15: r[aOut] = r[a1] shifted by 1, zero fill.
  - LOADSWITCH7: r[aOut] = zero-extended switch.
- Control opcodes (jump target = value[PC_WIDTH-1:0]):
  - JUMP3: pc = target.
  - IF0JUMP5: jump to target if r[a1] == 0, else pc+1.
  - IF1JUMP6: jump to target if r[a1] != 0, else pc+1.
  - CALL8: push pc+1, pc = target.
  - EXIT9: pop; pc = popped value.
  - RESET4: pc = 0, stack emptied; registers and fault unchanged.
- Any other opcode is a NOP: pc = pc+1.
- pc+1 wraps modulo 2^PC_WIDTH.
- Writes to register 0 are discarded.
- States:
  - RUN: execute when instrValid = 1; stall when instrValid = 0.
  - HALT: pc, registers and stack frozen; instrValid ignored. Left only by isReset.
- Stall (RUN, instrValid = 0): no pc, register, stack or fault change.

## Timing
- Each valid instruction completes in 1 cycle; results are visible on outputs the cycle after the edge.
- pc is registered. The instruction is sampled combinationally at that edge. Read-before-write applies within an instruction.
- A branch reads the register value as of the start of the cycle, so a value written by the previous instruction is visible.
- Reset values: pc = 0, all registers = 0, stackOffset = 0, fault = 0, halted = 0, state RUN.
- isReset has priority over instrValid, opcode and HALT.
- Stack boundaries:
  - CALL8 at stackOffset == STACK_DEPTH is an overflow.
  - EXIT9 at stackOffset == 0 is an underflow.
- CALL8 immediately followed by EXIT9 returns to the CALL address + 1. No bypass hazard exists; the push is written at the CALL edge.

## Configuration
- PUC_STACK_GUARD_EN, defined:
  - An overflow or underflow sets fault = 1 and enters HALT at that edge.
  - pc, registers and stack are left unchanged by the faulting instruction.
- PUC_STACK_GUARD_EN, undefined:
  - stackOffset wraps modulo STACK_DEPTH (its MSB stays 0). Overflow overwrites the oldest entry; underflow pops entry STACK_DEPTH-1.
  - fault and halted are tied to 0, and HALT is unreachable.

## Test plan
- Reset then LOAD0 value 0x05 into r1, INCREMENT11 r1->r1: register1Value = 0x06 after 2 cycles; pc = 2.
- ADD2 with r1 = 0xFF, r2 = 0x02 into r1: register1Value = 0x01 (wrap). LOAD0 to r0, then ADD2 r0+r0->r1: r1 = 0.
- Hold instrValid low for 3 cycles mid-program: pc and register1Value unchanged; execution resumes with the same instruction.
- CALL8 to 0x20 from pc 0x04, then EXIT9 at 0x20: pc = 0x20, then 0x05. stackOffset goes 1, then 0.
- With guard enabled, 17 nested CALL8 (depth 16): fault = 1, halted = 1, pc stays at the 17th CALL. isReset clears everything to reset values.
- With guard enabled, EXIT9 at depth 0: fault = 1, halted. With guard disabled, same program: pc = stack entry 15, stackOffset = 15.
